// File: rtl/burst_mem_responder.sv
// Burst memory responder: a 64-bit word memory serving variable-length read and
// write bursts over valid/ready beat channels, with a one-cycle completion pulse.
module burst_mem_responder #(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned LEN_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [63:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [63:0]      wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [63:0]      rd_data,
    output logic             rd_last,
    output logic             resp_valid,
    output logic             resp_err,
    output logic             busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StResp
    } state_e;

    state_e           state_q;
    logic [60:0]      idx_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] iss_q;
    logic             err_q;

    // Read output stage: the memory output register doubles as the beat register.
    logic             a_valid_q;
    logic             a_last_q;
    logic             a_zero_q;
    logic [63:0]      ram_q;

    logic [63:0]      mem [DEPTH];

    logic [61:0]      wr_word;
    logic [61:0]      iss_word;
    logic             wr_oor;
    logic             iss_oor;
    logic             wr_fire;
    logic             rd_fire;
    logic             issue;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^req_addr[2:0];

    // One extra bit keeps index+offset from wrapping back into valid memory.
    always_comb begin
        wr_word  = {1'b0, idx_q} + 62'(cnt_q);
        iss_word = {1'b0, idx_q} + 62'(iss_q);
        wr_oor   = wr_word >= 62'(DEPTH);
        iss_oor  = iss_word >= 62'(DEPTH);
        wr_fire  = (state_q == StWrite) && wr_valid;
        rd_fire  = a_valid_q && rd_ready;
        issue    = (state_q == StRead) && (iss_q != len_q) && (!a_valid_q || rd_ready);
    end

    always_ff @(posedge clk) begin
        if (wr_fire && !wr_oor) begin
            mem[wr_word[AW-1:0]] <= wr_data;
        end
        if (issue) begin
            ram_q <= mem[iss_word[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            iss_q     <= '0;
            err_q     <= 1'b0;
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_zero_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        idx_q <= req_addr[63:3];
                        len_q <= req_len;
                        cnt_q <= '0;
                        iss_q <= '0;
                        err_q <= 1'b0;
                        if (req_len == '0) begin
                            state_q <= StResp;
                        end else if (req_write) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StWrite: begin
                    if (wr_valid) begin
                        if (wr_oor) begin
                            err_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_q <= StResp;
                        end
                    end
                end
                StRead: begin
                    if (issue) begin
                        iss_q     <= iss_q + LEN_W'(1);
                        a_valid_q <= 1'b1;
                        a_last_q  <= (iss_q == len_q - LEN_W'(1));
                        a_zero_q  <= iss_oor;
                        if (iss_oor) begin
                            err_q <= 1'b1;
                        end
                    end else if (rd_fire) begin
                        a_valid_q <= 1'b0;
                    end
                    if (rd_fire) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (a_last_q) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign wr_ready   = (state_q == StWrite);
    assign rd_valid   = a_valid_q;
    assign rd_data    = a_zero_q ? 64'h0 : ram_q;
    assign rd_last    = a_valid_q && a_last_q;
    assign resp_valid = (state_q == StResp);
    assign resp_err   = (state_q == StResp) && err_q;

endmodule
